irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller directly upstream of the CPU control unit.
//  - Synchronises external interrupt lines and latches rising edges as pending.
//  - Tracks nested in-service interrupts.
//  - Drives min_bit_s (highest-priority pending) and min_bit_a (highest-priority in service) to the control unit.
//  - Consumes the control unit's s_calli (entry) and s_reti (return) strobes.
//  - Priority rule: lower bit index = higher priority. Bit 0 is reserved for ALU overflow.
// PARAMETERS
//  N_IRQ        8   number of interrupt lines; fixed at 8 to match the control unit buses
//  SYNC_STAGES  2   input synchroniser depth, >=2
// PORTS
//  clk         in   1      single clock; all state updates on its rising edge
//  reset       in   1      asynchronous, active-low; clears all state immediately
//  irq_in      in   8      async external requests; bit 0 ignored (reserved for overflow)
//  s_calli     in   8      one-hot interrupt-entry vector from the control unit
//  s_reti      in   8      one-hot interrupt-return vector from the control unit
//  mask_we     in   1      mask register write enable
//  mask_wdata  in   8      new mask value; 1 = line masked
//  min_bit_s   out  8      one-hot lowest set bit of (pending & ~mask); 0 if none
//  min_bit_a   out  8      one-hot lowest set bit of in_service; 0 if none
//  pending_o   out  8      raw pending register (debug/visibility)
// BEHAVIOUR
//  Reset values (reset=0, async):
//  - sync chain, edge history, pending, in_service, mask, s_calli/s_reti history all 0.
//  - Resulting outputs min_bit_s, min_bit_a, pending_o are all 0.
//  Request path:
//  - irq_in[i] passes through SYNC_STAGES flops plus one history flop.
//  - Sync-output rise (sync=1, history=0) sets pending[i] at the next edge.
//  - Latency: 3 rising edges from irq_in high to min_bit_s with SYNC_STAGES=2.
//  - A level held high generates exactly one event; a new event needs a low-then-high transition.
//  - pending[0] is never set.
//  Strobe sampling:
//  - The control unit holds s_calli/s_reti as levels, so each is registered.
//  - Only bits that rise (cur=1, prev=0) count as events.
//  Entry event on bit i: pending[i] <= 0 and in_service[i] <= 1 at the same edge.
//  Return event on bit i: in_service[i] <= 0.
//  Simultaneous events:
//  - New irq edge + entry, same bit, same cycle: pending stays 1 (request not lost); in_service set.
//  - Return + entry, same bit, same cycle: in_service ends 1 (entry wins).
//  - Events on different bits apply independently.
//  - Non-one-hot strobes: each bit processed independently; no error flag.
//  Outputs:
//  - min_bit_s and min_bit_a are combinational from registers only, so no comb loop through the control unit.
//  - min_bit_s = x & (~x + 1) with x = pending & ~mask; min_bit_a computed the same way on in_service.
//  - Nesting is allowed. Preemption is decided by the control unit (min_bit_s < min_bit_a); this block does not compare.
//  - Return event with in_service bit already 0: no-op.
//  - Return clears only the named bit; lower-priority in-service bits remain, so min_bit_a falls back to the outer interrupt.
//  Mask writes:
//  - mask_we=1: mask <= mask_wdata at the edge.
//  - Masking hides a bit from min_bit_s but pending still latches.
//  - Unmasking exposes min_bit_s in the same cycle as the mask update.
//  Reset asserted mid-service: all state cleared; a held irq_in re-fires once after reset release via sync rise.
// CONFIGURATION
//  IRQ_MASK_EN defined:
//  - mask register is implemented and written as above.
//  IRQ_MASK_EN undefined:
//  - no mask register; mask is constant 0.
//  - mask_we and mask_wdata are ignored (ports kept for a fixed interface).
//  - min_bit_s is the lowest set bit of pending.
// STRUCTURE
//  Shared include irq_defs.vh:
//  - N_IRQ, IRQ_OVF_BIT=0, IRQ_NONE=8'b0.
//  Sub-module lsb_onehot #(W):
//  - combinational lowest-set-bit isolator, instantiated twice (pending path, in-service path).
//  Top level holds the sync chains, edge detectors, pending/in_service/mask registers.
// TESTING
//  1 reset=0 with irq_in=8'hFF -> all outputs 0; release -> min_bit_s=8'h02 after 3 edges.
//  2 irq_in[3] 0->1 -> min_bit_s=8'h08 after 3 edges; s_calli=8'h08 held -> next edge min_bit_s=0, min_bit_a=8'h08; held s_calli causes no further change.
//  3 in_service=8'h08, irq_in[1] rises -> min_bit_s=8'h02; s_calli=8'h02 -> min_bit_a=8'h02; s_reti=8'h02 -> min_bit_a=8'h08.
//  4 irq_in[5] and irq_in[2] rise together -> min_bit_s=8'h04; after entry on bit 2 -> min_bit_s=8'h20.
//  5 IRQ_MASK_EN: mask=8'h04, irq_in[2] rises -> pending_o=8'h04, min_bit_s=0; mask=0 -> min_bit_s=8'h04. Undefined: min_bit_s=8'h04 directly.
//  6 irq_in[0] toggles -> pending_o stays 0; s_calli=8'h01 -> min_bit_a=8'h01; reset pulse mid-service -> min_bit_a=0 asynchronously.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Contents: line count, overflow bit position, empty-vector constant,
// the vector type, the request mask that drops the overflow bit, and a
// rising-edge helper used on both the request and strobe paths.
package irq_ctrl_pkg;

   localparam int unsigned N_IRQ       = 8;
   localparam int unsigned IRQ_OVF_BIT = 0;

   typedef logic [N_IRQ-1:0] irq_vec_t;

   localparam irq_vec_t IRQ_NONE = '0;

   // External requests never reach the overflow bit; it is entered only via s_calli.
   localparam irq_vec_t IRQ_REQ_MASK = ~(irq_vec_t'(1) << IRQ_OVF_BIT);

   // Bits that are high now but were low one cycle earlier.
   function automatic irq_vec_t rise(input irq_vec_t cur, input irq_vec_t prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/irq_ctrl_lsb_onehot.sv
// Combinational lowest-set-bit isolator.
// Ports:
//   x      in  W  input vector
//   lsb_c  out W  one-hot copy of the lowest set bit of x, 0 if x is 0
module lsb_onehot #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] x,
   output logic [W-1:0] lsb_c
);

   // Two's-complement trick: x & -x keeps only the lowest set bit.
   assign lsb_c = x & (~x + W'(1));

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller feeding the CPU control unit.
// Synchronises external requests, latches their rising edges as pending,
// tracks nested in-service interrupts and reports the highest-priority
// (lowest index) pending and in-service lines as one-hot vectors.
// Configuration macro: IRQ_MASK_EN -- when defined a mask register hides
// lines from min_bit_s; when undefined the mask is constant 0 and
// mask_we/mask_wdata are ignored.
// Ports:
//   clk         in  1  clock, rising edge
//   reset       in  1  asynchronous, active-low, clears all state
//   irq_in      in  8  asynchronous requests, bit 0 ignored
//   s_calli     in  8  entry strobe level from the control unit
//   s_reti      in  8  return strobe level from the control unit
//   mask_we     in  1  mask write enable
//   mask_wdata  in  8  new mask value, 1 = masked
//   min_bit_s   out 8  lowest set bit of pending & ~mask (combinational from registers)
//   min_bit_a   out 8  lowest set bit of in_service (combinational from registers)
//   pending_o   out 8  raw pending register
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_IRQ-1:0] irq_in,
   input  logic [N_IRQ-1:0] s_calli,
   input  logic [N_IRQ-1:0] s_reti,
   input  logic             mask_we,
   input  logic [N_IRQ-1:0] mask_wdata,
   output logic [N_IRQ-1:0] min_bit_s,
   output logic [N_IRQ-1:0] min_bit_a,
   output logic [N_IRQ-1:0] pending_o
);

   logic [SYNC_STAGES-1:0][N_IRQ-1:0] sync_q;
   irq_vec_t sync_out;
   irq_vec_t hist_q;
   irq_vec_t calli_q;
   irq_vec_t reti_q;
   irq_vec_t pending_q;
   irq_vec_t in_service_q;
   irq_vec_t mask;
   irq_vec_t irq_edge;
   irq_vec_t entry_ev;
   irq_vec_t return_ev;
   irq_vec_t visible_pending;

   // Synchroniser chain; stage 0 captures the raw asynchronous lines.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], irq_in & IRQ_REQ_MASK};
      end
   end

   assign sync_out = sync_q[SYNC_STAGES-1];

   // History of the synchronised lines and of the strobe levels.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist_q  <= '0;
         calli_q <= '0;
         reti_q  <= '0;
      end else begin
         hist_q  <= sync_out;
         calli_q <= s_calli;
         reti_q  <= s_reti;
      end
   end

   assign irq_edge  = rise(sync_out, hist_q) & IRQ_REQ_MASK;
   assign entry_ev  = rise(s_calli, calli_q);
   assign return_ev = rise(s_reti, reti_q);

   // A fresh edge overrides an entry on the same bit so the request is not lost;
   // an entry overrides a return on the same bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_q    <= '0;
         in_service_q <= '0;
      end else begin
         pending_q    <= (pending_q & ~entry_ev) | irq_edge;
         in_service_q <= (in_service_q & ~return_ev) | entry_ev;
      end
   end

`ifdef IRQ_MASK_EN
   irq_vec_t mask_q;

   // Mask register; pending still latches behind a mask.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
      end else if (mask_we) begin
         mask_q <= mask_wdata;
      end
   end

   assign mask = mask_q;
`else
   logic unused_mask_port;

   // Mask ports kept for a fixed interface but have no effect in this build.
   assign unused_mask_port = ^{mask_we, mask_wdata};
   assign mask             = IRQ_NONE;
`endif

   assign visible_pending = pending_q & ~mask;

   lsb_onehot #(
      .W (N_IRQ)
   ) u_lsb_pending (
      .x     (visible_pending),
      .lsb_c (min_bit_s)
   );

   lsb_onehot #(
      .W (N_IRQ)
   ) u_lsb_in_service (
      .x     (in_service_q),
      .lsb_c (min_bit_a)
   );

   assign pending_o = pending_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: a table of per-cycle vectors for the
// main request/entry/return flow, then hand-written multi-cycle sequences
// for masking, simultaneous events, the overflow bit and mid-service reset.
module tb_irq_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] irq_in;
   logic [7:0] s_calli;
   logic [7:0] s_reti;
   logic       mask_we;
   logic [7:0] mask_wdata;
   logic [7:0] min_bit_s;
   logic [7:0] min_bit_a;
   logic [7:0] pending_o;

   int total;
   int bad;

`ifdef IRQ_MASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   typedef struct {
      logic       rst;
      logic [7:0] irq;
      logic [7:0] calli;
      logic [7:0] reti;
      logic [7:0] exp_s;
      logic [7:0] exp_a;
      logic [7:0] exp_p;
   } vec_t;

   vec_t tbl[$];

   irq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .s_calli    (s_calli),
      .s_reti     (s_reti),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .min_bit_s  (min_bit_s),
      .min_bit_a  (min_bit_a),
      .pending_o  (pending_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic rst, input logic [7:0] irq, input logic [7:0] calli,
                        input logic [7:0] reti, input logic we, input logic [7:0] wd);
      reset      = rst;
      irq_in     = irq;
      s_calli    = calli;
      s_reti     = reti;
      mask_we    = we;
      mask_wdata = wd;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] es, input logic [7:0] ea,
                      input logic [7:0] ep);
      total += 3;
      if (min_bit_s !== es) begin
         bad++;
         $display("FAIL %s min_bit_s: got %h want %h", name, min_bit_s, es);
      end
      if (min_bit_a !== ea) begin
         bad++;
         $display("FAIL %s min_bit_a: got %h want %h", name, min_bit_a, ea);
      end
      if (pending_o !== ep) begin
         bad++;
         $display("FAIL %s pending_o: got %h want %h", name, pending_o, ep);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;

      //                rst   irq    calli  reti   s      a      p
      // reset held with all requests high, then release
      tbl.push_back('{1'b0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFE});
      tbl.push_back('{1'b1, 8'hFF, 8'h00, 8'h00, 8'h02, 8'h00, 8'hFE});
      tbl.push_back('{1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      // irq 3 request, entry, held entry strobe
      tbl.push_back('{1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00, 8'h08});
      tbl.push_back('{1'b1, 8'h08, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h08, 8'h08, 8'h00, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00});
      // nested irq 1 over in-service irq 3, then return falls back
      tbl.push_back('{1'b1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h02, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h02, 8'h00, 8'h00, 8'h02, 8'h08, 8'h02});
      tbl.push_back('{1'b1, 8'h02, 8'h02, 8'h00, 8'h00, 8'h02, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h02, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h08, 8'h00});
      // return on a bit not in service is a no-op, then return irq 3
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h04, 8'h00, 8'h08, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h08, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      // irq 5 and 2 together; priority, then non-one-hot return
      tbl.push_back('{1'b1, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h24, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h24, 8'h00, 8'h00, 8'h04, 8'h00, 8'h24});
      tbl.push_back('{1'b1, 8'h24, 8'h04, 8'h00, 8'h20, 8'h04, 8'h20});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h20, 8'h04, 8'h20});
      tbl.push_back('{1'b1, 8'h00, 8'h20, 8'h00, 8'h00, 8'h04, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h24, 8'h00, 8'h00, 8'h00});
      tbl.push_back('{1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

      // asynchronous reset state before any clock edge
      drive(1'b0, 8'hFF, 8'h00, 8'h00, 1'b0, 8'h00);
      #3;
      chk("reset_async", 8'h00, 8'h00, 8'h00);
      tick();

      foreach (tbl[i]) begin
         drive(tbl[i].rst, tbl[i].irq, tbl[i].calli, tbl[i].reti, 1'b0, 8'h00);
         tick();
         chk($sformatf("row%0d", i), tbl[i].exp_s, tbl[i].exp_a, tbl[i].exp_p);
      end

      // mask hides a latched request; unmasking exposes it on the write edge
      drive(1'b1, 8'h04, 8'h00, 8'h00, 1'b1, 8'h04);
      tick();
      chk("mask_c1", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h04, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("mask_c2", 8'h00, 8'h00, 8'h00);
      tick();
      chk("mask_hidden", MASK_EN ? 8'h00 : 8'h04, 8'h00, 8'h04);
      drive(1'b1, 8'h04, 8'h00, 8'h00, 1'b1, 8'h00);
      tick();
      chk("mask_clear", 8'h04, 8'h00, 8'h04);
      drive(1'b1, 8'h04, 8'h04, 8'h00, 1'b0, 8'h00);
      tick();
      chk("mask_entry", 8'h00, 8'h04, 8'h00);
      drive(1'b1, 8'h00, 8'h00, 8'h04, 1'b0, 8'h00);
      tick();
      chk("mask_ret", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();

      // new edge and entry on the same bit in the same cycle keeps pending
      drive(1'b1, 8'h08, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick(); tick();
      chk("sim_pend", 8'h08, 8'h00, 8'h08);
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick(); tick();
      chk("sim_low", 8'h08, 8'h00, 8'h08);
      drive(1'b1, 8'h08, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick();
      drive(1'b1, 8'h08, 8'h08, 8'h00, 1'b0, 8'h00);
      tick();
      chk("edge_and_entry", 8'h08, 8'h08, 8'h08);
      drive(1'b1, 8'h08, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("hold_level", 8'h08, 8'h08, 8'h08);
      // return and entry on the same bit: entry wins
      drive(1'b1, 8'h08, 8'h08, 8'h08, 1'b0, 8'h00);
      tick();
      chk("ret_and_entry", 8'h00, 8'h08, 8'h00);
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      drive(1'b1, 8'h00, 8'h00, 8'h08, 1'b0, 8'h00);
      tick();
      chk("sim_ret", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();

      // overflow bit never pends from irq_in but can be entered
      drive(1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick(); tick();
      chk("ovf_irq_a", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      drive(1'b1, 8'h01, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick(); tick();
      chk("ovf_irq_b", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h00, 8'h01, 8'h00, 1'b0, 8'h00);
      tick();
      chk("ovf_entry", 8'h00, 8'h01, 8'h00);

      // reset mid-service clears immediately; a held request re-fires once
      drive(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00);
      tick(); tick(); tick();
      chk("pre_reset", 8'h10, 8'h01, 8'h10);
      drive(1'b0, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00);
      #2;
      chk("reset_mid_async", 8'h00, 8'h00, 8'h00);
      tick();
      chk("reset_mid_held", 8'h00, 8'h00, 8'h00);
      drive(1'b1, 8'h10, 8'h00, 8'h00, 1'b0, 8'h00);
      tick();
      chk("refire_c1", 8'h00, 8'h00, 8'h00);
      tick();
      chk("refire_c2", 8'h00, 8'h00, 8'h00);
      tick();
      chk("refire_c3", 8'h10, 8'h00, 8'h10);
      tick();
      chk("refire_once", 8'h10, 8'h00, 8'h10);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
